// File: rtl/anita4_trig_pattern_buffer_if.sv
// anita4_trig_pattern_buffer_if: valid/ready readout channel carrying one event entry
interface anita4_trig_pattern_buffer_if #(parameter int W = 56);
  logic [W-1:0] dat;
  logic         valid;
  logic         ready;
  modport master (output dat, valid, input ready);
  modport slave  (input dat, valid, output ready);
endinterface

// File: rtl/anita4_trig_pattern_buffer.sv
// anita4_trig_pattern_buffer: stages trigger phi pattern + delayed count + timestamp into a FWFT FIFO with drop accounting
module anita4_trig_pattern_buffer #(
  parameter int NUM_PHI     = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int TS_BITS     = 16,
  parameter int COUNT_DELAY = 4
) (
  input  logic                     clk250_i,
  input  logic                     rst_i,
  input  logic                     trig_i,
  input  logic [2*NUM_PHI-1:0]     phi_i,
  input  logic [7:0]               count_i,
  input  logic                     enable_i,
  anita4_trig_pattern_buffer_if.master rd,
  output logic [DEPTH_LOG2:0]      fill_o,
  output logic [7:0]               dropped_o,
  output logic                     overflow_o
);
  localparam int PW = 2*NUM_PHI;
  localparam int W  = PW + 8 + TS_BITS;
  localparam logic [DEPTH_LOG2:0] DEPTH_F = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                state_q, state_d;
  logic [TS_BITS-1:0]    ts_q, ts_d, st_ts_q, st_ts_d;
  logic [PW-1:0]         st_phi_q, st_phi_d;
  logic [3:0]            dly_q, dly_d;
  logic                  trig_q;
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic [7:0]            dropped_q, dropped_d;
  logic                  ovf_q, ovf_d;
  logic [W-1:0]          mem_q [1 << DEPTH_LOG2];
  logic                  en_edge, wr_att, pop, push, stage_drop, fifo_drop;
  logic [8:0]            drop_sum;
  always_comb begin
    en_edge    = trig_i & ~trig_q & enable_i;
    wr_att     = (state_q == WAIT) && (dly_q == 4'd0);
    pop        = rd.valid & rd.ready;
    push       = wr_att && (fill_q != DEPTH_F || pop);
    fifo_drop  = wr_att & ~push;
    stage_drop = (state_q == WAIT) & en_edge;
    drop_sum   = {1'b0, dropped_q} + 9'(stage_drop) + 9'(fifo_drop);
    dropped_d  = drop_sum > 9'd255 ? 8'hFF : drop_sum[7:0];
    ovf_d      = ovf_q | stage_drop | fifo_drop;
    ts_d       = ts_q + TS_BITS'(1);
    state_d    = state_q == IDLE ? (en_edge ? WAIT : IDLE) : (wr_att ? IDLE : WAIT);
    dly_d      = state_q == IDLE ? 4'(COUNT_DELAY-1) : dly_q - 4'd1;
    st_phi_d   = (state_q == IDLE && en_edge) ? phi_i : st_phi_q;
    st_ts_d    = (state_q == IDLE && en_edge) ? ts_q : st_ts_q;
    wr_d       = wr_q + DEPTH_LOG2'(push);
    rd_d       = rd_q + DEPTH_LOG2'(pop);
    fill_d     = fill_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  end
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      st_ts_q   <= '0;
      st_phi_q  <= '0;
      dly_q     <= '0;
      trig_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      fill_q    <= '0;
      dropped_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      st_ts_q   <= st_ts_d;
      st_phi_q  <= st_phi_d;
      dly_q     <= dly_d;
      trig_q    <= trig_i;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fill_q    <= fill_d;
      dropped_q <= dropped_d;
      ovf_q     <= ovf_d;
    end
  end
  // storage needs no reset; a full-FIFO push may overwrite the slot being popped this cycle
  always_ff @(posedge clk250_i) begin
    if (!rst_i && push) mem_q[wr_q] <= {st_ts_q, count_i, st_phi_q};
  end
  assign rd.valid   = fill_q != '0;
  assign rd.dat     = mem_q[rd_q];
  assign fill_o     = fill_q;
  assign dropped_o  = dropped_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_anita4_trig_pattern_buffer.sv
// tb_anita4_trig_pattern_buffer: random + directed stimulus against an event-level model with a scoreboard monitor
module tb_anita4_trig_pattern_buffer;
  localparam int PW = 32, W = 56, D = 16, CD = 4;
  logic clk = 0, rst = 1, trig = 0, en = 1, rdy = 0;
  logic [PW-1:0] phi = '0;
  logic [7:0] cnt = '0, dropped;
  logic [4:0] fill;
  logic ovf;
  int checks = 0, errs = 0;
  anita4_trig_pattern_buffer_if #(.W(W)) rd_if ();
  assign rd_if.ready = rdy;
  always #2 clk = ~clk;
  anita4_trig_pattern_buffer dut (
    .clk250_i(clk), .rst_i(rst), .trig_i(trig), .phi_i(phi), .count_i(cnt),
    .enable_i(en), .rd(rd_if), .fill_o(fill), .dropped_o(dropped), .overflow_o(ovf)
  );
  int m_fill = 0, m_drop = 0;
  bit m_ovf = 0, m_prev = 0, m_pend = 0;
  logic [15:0] m_ts = '0, p_ts;
  logic [PW-1:0] p_phi;
  longint cyc = 0, due = 0;
  logic [W-1:0] exp_q[$];
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endfunction
  // event-level reference: one pending trigger resolved COUNT_DELAY cycles after its edge
  always @(posedge clk) begin : model
    int drops;
    bit pop, edge_en;
    if (rst) begin
      m_ts = '0; m_prev = 0; m_pend = 0; m_fill = 0; m_drop = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      drops = 0;
      pop = m_fill > 0 && rdy;
      edge_en = trig && !m_prev && en;
      if (m_pend && edge_en) drops++;
      if (m_pend && cyc == due) begin
        m_pend = 0;
        if (m_fill < D || pop) begin
          exp_q.push_back({p_ts, cnt, p_phi});
          m_fill++;
        end else drops++;
      end else if (!m_pend && edge_en) begin
        m_pend = 1; due = cyc + CD; p_ts = m_ts; p_phi = phi;
      end
      if (pop) m_fill--;
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      if (drops > 0) m_ovf = 1;
      m_ts++;
      m_prev = trig;
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("fill", 64'(fill), 64'(m_fill));
      chk("valid", 64'(rd_if.valid), 64'(m_fill != 0));
      chk("dropped", 64'(dropped), 64'(m_drop));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      if (rd_if.valid && rdy) begin
        if (exp_q.size() == 0) chk("dat_unexpected", 64'(rd_if.dat), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("dat", 64'(rd_if.dat), 64'(exp_q.pop_front()));
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      cnt = 8'($urandom);
    end
  endtask
  task automatic pulse(int len, logic [PW-1:0] p);
    trig = 1; phi = p; tick(1);
    phi = $urandom; tick(len - 1);
    trig = 0;
  endtask
  task automatic do_reset();
    rst = 1; tick(2); rst = 0;
  endtask
  task automatic drain(int n);
    rdy = 1; tick(n); rdy = 0;
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic fill_n(int n);
    repeat (n) begin pulse(2, $urandom); tick(6); end
  endtask
  initial begin
    tick(3); rst = 0;
    for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) tick(1);
    chk("ts_reach_ffff", 64'(m_ts), 64'hFFFF);
    pulse(1, 32'hA5A5_5A5A); tick(1);
    chk("ts_wrapped", 64'(m_ts), 64'd1);
    tick(6); drain(4);
    do_reset(); tick(7);
    pulse(3, 32'h0003_0001); tick(8); drain(4);
    pulse(1, $urandom); tick(1); pulse(1, $urandom); tick(8); drain(4);
    fill_n(17); drain(24);
    fill_n(16); pulse(1, $urandom); tick(3);
    rdy = 1; tick(1); rdy = 0; tick(3); drain(24);
    fill_n(16);
    repeat (350) begin trig = 1; tick(1); trig = 0; tick(1); end
    drain(24);
    en = 0; repeat (10) begin pulse(1, $urandom); tick(2); end
    en = 1; pulse(1, $urandom); en = 0; tick(6); en = 1; drain(4);
    do_reset();
    repeat (3000) begin
      trig = $urandom_range(0, 3) == 0;
      en = $urandom_range(0, 7) != 0;
      rdy = $urandom_range(0, 1) == 1;
      phi = $urandom;
      tick(1);
    end
    trig = 0; en = 1; tick(6); drain(24);
    do_reset(); fill_n(3); pulse(1, $urandom); tick(1);
    rst = 1; tick(1); rst = 0; tick(10);
    fill_n(1); drain(4);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
